dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 156 +++++++++++++++
 tb/tb_dmem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store with WAIT_CYCLES wait states.
// Optional macro DMEM_ERR_EN flags misaligned, reserved-size and out-of-range accesses.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);
  localparam bit          NoWait   = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          wr_q, uns_q;
  logic [1:0]    size_q;
  logic [31:0]   addr_q, wdata_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          idle, sel_wr, sel_uns, err, enter_resp, we;
  logic [1:0]    sel_size, size_eff, off;
  logic [31:0]   sel_addr, sel_wdata, wdata_sh, rd_sh, load_data, rdata_d;
  logic [3:0]    be;
  logic [AW-1:0] idx;

  assign idle      = (state_q == StIdle);
  assign req_ready = idle;

  // In IDLE the live request is decoded so a zero-wait access completes on its accept edge.
  assign sel_wr    = idle ? req_write    : wr_q;
  assign sel_uns   = idle ? req_unsigned : uns_q;
  assign sel_size  = idle ? req_size     : size_q;
  assign sel_addr  = idle ? req_addr     : addr_q;
  assign sel_wdata = idle ? req_wdata    : wdata_q;
  assign idx       = sel_addr[AW+1:2];

  always_comb begin
    size_eff = (sel_size == 2'b11) ? 2'b10 : sel_size;
    off      = 2'b00;
    be       = 4'b1111;
    case (size_eff)
      2'b00: begin
        off = sel_addr[1:0];
        be  = 4'b0001 << sel_addr[1:0];
      end
      2'b01: begin
        off = {sel_addr[1], 1'b0};
        be  = 4'b0011 << {sel_addr[1], 1'b0};
      end
      default: ;
    endcase
  end

  assign wdata_sh = sel_wdata << {off, 3'b000};
  assign rd_sh    = mem[idx] >> {off, 3'b000};

  always_comb begin
    case (size_eff)
      2'b00:   load_data = sel_uns ? {24'd0, rd_sh[7:0]} : {{24{rd_sh[7]}}, rd_sh[7:0]};
      2'b01:   load_data = sel_uns ? {16'd0, rd_sh[15:0]} : {{16{rd_sh[15]}}, rd_sh[15:0]};
      default: load_data = rd_sh;
    endcase
  end

`ifdef DMEM_ERR_EN
  assign err = (sel_size == 2'b01 && sel_addr[0]) ||
               (sel_size == 2'b10 && sel_addr[1:0] != 2'b00) ||
               (sel_size == 2'b11) ||
               ((sel_addr >> (AW + 2)) != 32'd0);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^sel_addr;
  assign err = 1'b0;
`endif

  assign rdata_d    = (sel_wr || err) ? 32'd0 : load_data;
  assign enter_resp = (idle && req_valid && NoWait) || (state_q == StWait && cnt_q == 4'd1);
  assign we         = enter_resp && sel_wr && !err;

  // Array is not reset; a reset in WAIT leaves the FSM idle so no write occurs.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      wr_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            wr_q    <= req_write;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (NoWait) begin
              state_q   <= StResp;
              rsp_valid <= 1'b1;
              rsp_rdata <= rdata_d;
              rsp_err   <= err;
            end else begin
              state_q <= StWait;
              cnt_q   <= WaitInit;
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q   <= StResp;
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata_d;
            rsp_err   <= err;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q   <= StIdle;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder (WAIT_CYCLES=2 main instance, 0-wait instance).
module tb_dmem_responder;

  localparam int unsigned W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned, rsp_valid, rsp_ready, rsp_err;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        req_valid0, req_ready0, req_write0, rsp_valid0, rsp_err0;
  logic [31:0] req_addr0, req_wdata0, rsp_rdata0;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat;
  logic [32:0] sb  [$];
  logic [32:0] sb0 [$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write0), .req_size(2'b10), .req_unsigned(1'b0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .rsp_valid(rsp_valid0),
    .rsp_ready(1'b1), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request and returns #1 after its accept edge with lat=1.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic push, input logic exp_e, input logic [31:0] exp_d);
    int n;
    if (push) sb.push_back({exp_e, exp_d});
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 33'(n < 50), 33'd1);
    @(posedge clk); #1;
    lat = 1;
    // Scramble the request after accept; the pending access must not change.
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic await_rsp(input string tag);
    logic [32:0] e;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 33'(lat), 33'(W + 1));
    chk({tag, "_sb"}, 33'(sb.size() != 0), 33'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_data"}, {1'b0, rsp_rdata}, {1'b0, e[31:0]});
      chk({tag, "_err"}, {32'd0, rsp_err}, {32'd0, e[32]});
    end
    if (rsp_ready) begin
      @(posedge clk); #1;
      chk({tag, "_idle"}, {rsp_err, rsp_rdata}, 33'd0);
      chk({tag, "_vld0"}, {32'd0, rsp_valid}, 33'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_w;
    logic        exp_e;
    reset = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0;
    #12;
    chk("rst_valid", {32'd0, rsp_valid}, 33'd0);
    chk("rst_out", {rsp_err, rsp_rdata}, 33'd0);
    @(negedge clk); reset = 1'b1; #1;
    chk("rst_ready", {32'd0, req_ready}, 33'd1);

    // Word store/load with latency check.
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    await_rsp("st_word");
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
    await_rsp("ld_word");

    // Byte lanes and extension.
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0);
    await_rsp("st_zero");
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'hABCDEF80, 1'b1, 1'b0, 32'h0);
    await_rsp("st_byte");
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h00008000);
    await_rsp("ld_w_after_b");
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b1, 1'b0, 32'hFFFFFF80);
    await_rsp("ld_b_signed");
    issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b1, 1'b0, 32'h00000080);
    await_rsp("ld_b_unsigned");

    // Back-pressure: response held, second request waits for the handshake.
    rsp_ready = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h00008000);
    await_rsp("hold_first");
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h11;
    sb.push_back({1'b0, 32'hFFFFFF80});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {32'd0, rsp_valid}, 33'd1);
      chk("hold_data", {1'b0, rsp_rdata}, 33'h00008000);
      chk("hold_ready", {32'd0, req_ready}, 33'd0);
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bubble_valid", {32'd0, rsp_valid}, 33'd0);
    chk("bubble_ready", {32'd0, req_ready}, 33'd1);
    @(posedge clk); #1;
    chk("second_accepted", {32'd0, req_ready}, 33'd0);
    lat = 1; req_valid = 1'b0;
    await_rsp("hold_second");

    // Halfword lanes.
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF, 1'b1, 1'b0, 32'h0);
    await_rsp("st_half");
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0, 32'hFFFFBEEF);
    await_rsp("ld_h_signed");
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1, 1'b0, 32'h0000BEEF);
    await_rsp("ld_h_unsigned");
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hBEEF8000);
    await_rsp("ld_w_after_h");

    // Reset during WAIT drops the store.
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h11112222, 1'b1, 1'b0, 32'h0);
    await_rsp("st_prior");
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 1'b0, 1'b0, 32'h0);
    @(negedge clk); reset = 1'b0; #1;
    chk("rstw_valid", {32'd0, rsp_valid}, 33'd0);
    chk("rstw_out", {rsp_err, rsp_rdata}, 33'd0);
    repeat (4) @(negedge clk);
    reset = 1'b1; #1;
    chk("rstw_ready", {32'd0, req_ready}, 33'd1);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h11112222);
    await_rsp("ld_after_rst");

`ifdef DMEM_ERR_EN
    exp_e = 1'b1;
`else
    exp_e = 1'b0;
`endif
    exp_w = exp_e ? 32'h0 : 32'h11112222;
    issue(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 1'b1, exp_e, exp_w);
    await_rsp("ld_misaligned");
    issue(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1'b1, exp_e, exp_w);
    await_rsp("ld_size11");
    exp_w = exp_e ? 32'h0 : 32'hBEEF8000;
    issue(1'b0, 2'b10, 1'b0, 32'h1010, 32'h0, 1'b1, exp_e, exp_w);
    await_rsp("ld_wrap");

    // Zero-wait instance: store then back-to-back loads held valid.
    sb0.push_back({1'b0, 32'h0});
    for (int i = 0; i < 3; i++) sb0.push_back({1'b0, 32'hCAFEF00D});
    @(negedge clk);
    req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 32'h8; req_wdata0 = 32'hCAFEF00D;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (k == 1) req_write0 = 1'b0;
      chk("w0_valid", {32'd0, rsp_valid0}, 33'(k % 2));
      chk("w0_ready", {32'd0, req_ready0}, 33'((k + 1) % 2));
      if (rsp_valid0 && sb0.size() != 0) begin
        chk("w0_data", {rsp_err0, rsp_rdata0}, sb0.pop_front());
      end
    end
    req_valid0 = 1'b0;
    chk("w0_sb_empty", 33'(sb0.size()), 33'd0);
    @(posedge clk); #1;
    chk("w0_idle", {32'd0, rsp_valid0}, 33'd0);
    chk("sb_empty", 33'(sb.size()), 33'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
